// File: rtl/pc_next_unit.sv
// Next-PC generator with a one-instruction branch delay slot and a halt on jump-to-HALT_ADDR.
// Redirects at the second enabled edge after a request; clk_enable low freezes all state.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_current,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] pc_next,
  output logic        delay_slot,
  output logic        active
);

  typedef enum logic [1:0] {
    SEQ   = 2'd0,
    DELAY = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] sel_tgt;
  logic        redirect_req;

  // All targets are relative to the instruction after the one now executing.
  assign pc_plus4     = pc_current + 32'd4;
  assign branch_tgt   = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_tgt     = {pc_plus4[31:28], jump_index, 2'b00};
  assign redirect_req = jump_reg | jump | branch_taken;

  always_comb begin
    sel_tgt = branch_tgt;
    if (jump_reg) begin
      sel_tgt = jump_reg_target;
    end else if (jump) begin
      sel_tgt = jump_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEQ;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (clk_enable) begin
      case (state_q)
        SEQ: begin
          if (redirect_req) begin
            state_d  = DELAY;
            target_d = sel_tgt;
          end
        end
        DELAY: begin
          state_d = (target_q == HALT_ADDR) ? HALT : SEQ;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = SEQ;
        end
      endcase
    end
  end

  always_comb begin
    pc_next    = pc_plus4;
    delay_slot = 1'b0;
    active     = 1'b1;
    if (reset) begin
      pc_next = RESET_VECTOR;
    end else begin
      case (state_q)
        SEQ:     pc_next = pc_plus4;
        DELAY:   pc_next = target_q;
        HALT:    pc_next = pc_current;
        default: pc_next = pc_plus4;
      endcase
    end
    // Flags follow the registered state only, so they stay glitch-free under reset.
    delay_slot = (state_q == DELAY);
    active     = (state_q != HALT);
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench: a PC register loops pc_next back to pc_current under clk_enable.
module tb_pc_next_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic [31:0] pc_next;
  logic        delay_slot;
  logic        active;

  int n_cmp;
  int n_err;

  pc_next_unit dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .pc_current      (pc_current),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .jump_index      (jump_index),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .pc_next         (pc_next),
    .delay_slot      (delay_slot),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the PC register sharing clk_enable with the unit.
  always @(posedge clk) begin
    if (clk_enable) pc_current <= pc_next;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    branch_taken    = 1'b0;
    branch_offset   = 16'h0000;
    jump            = 1'b0;
    jump_index      = 26'h0;
    jump_reg        = 1'b0;
    jump_reg_target = 32'h0;
  endtask

  task automatic do_reset();
    clear_req();
    clk_enable = 1'b1;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pc_next !== 32'hBFC00000) begin
      n_err++; $display("FAIL reset_pc_next: got %h want BFC00000", pc_next);
    end
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (pc_current !== 32'hBFC00000 || delay_slot !== 1'b0 || active !== 1'b1) begin
      n_err++; $display("FAIL reset_state: pc %h ds %b act %b want BFC00000 0 1", pc_current, delay_slot, active);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hBFC00004;
    exp_pc[1] = 32'hBFC00008;
    exp_pc[2] = 32'hBFC0000C;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (pc_current !== exp_pc[i] || delay_slot !== 1'b0 || active !== 1'b1) begin
        n_err++; $display("FAIL seq_%0d: pc %h ds %b act %b want %h 0 1", i, pc_current, delay_slot, active, exp_pc[i]);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    step();
    clear_req();
    n_cmp++;
    if (pc_current !== 32'hBFC00004 || delay_slot !== 1'b1 || pc_next !== 32'hBFC00010) begin
      n_err++; $display("FAIL br_fwd_slot: pc %h ds %b nxt %h want BFC00004 1 BFC00010", pc_current, delay_slot, pc_next);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'hBFC00010 || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL br_fwd_tgt: pc %h ds %b want BFC00010 0", pc_current, delay_slot);
    end
    branch_taken  = 1'b1;
    branch_offset = 16'hFFFE;
    step();
    clear_req();
    n_cmp++;
    if (pc_current !== 32'hBFC00014 || delay_slot !== 1'b1) begin
      n_err++; $display("FAIL br_back_slot: pc %h ds %b want BFC00014 1", pc_current, delay_slot);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'hBFC0000C || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL br_back_tgt: pc %h ds %b want BFC0000C 0", pc_current, delay_slot);
    end
  endtask

  task automatic test_jump();
    do_reset();
    jump          = 1'b1;
    jump_index    = 26'h0000040;
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    step();
    clear_req();
    n_cmp++;
    if (pc_current !== 32'hBFC00004 || delay_slot !== 1'b1) begin
      n_err++; $display("FAIL jump_slot: pc %h ds %b want BFC00004 1", pc_current, delay_slot);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'hB0000100 || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL jump_tgt: pc %h ds %b want B0000100 0", pc_current, delay_slot);
    end
  endtask

  task automatic test_priority();
    do_reset();
    jump_reg        = 1'b1;
    jump_reg_target = 32'hBFC00200;
    jump            = 1'b1;
    jump_index      = 26'h0000040;
    branch_taken    = 1'b1;
    branch_offset   = 16'h0003;
    step();
    clear_req();
    n_cmp++;
    if (pc_next !== 32'hBFC00200 || delay_slot !== 1'b1) begin
      n_err++; $display("FAIL prio_slot: nxt %h ds %b want BFC00200 1", pc_next, delay_slot);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'hBFC00200) begin
      n_err++; $display("FAIL prio_tgt: pc %h want BFC00200", pc_current);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_reg        = 1'b1;
    jump_reg_target = 32'hFFFFFFFC;
    step();
    clear_req();
    step();
    n_cmp++;
    if (pc_current !== 32'hFFFFFFFC || pc_next !== 32'h00000000) begin
      n_err++; $display("FAIL wrap_next: pc %h nxt %h want FFFFFFFC 00000000", pc_current, pc_next);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'h00000000 || active !== 1'b1 || pc_next !== 32'h00000004) begin
      n_err++; $display("FAIL wrap_seq: pc %h act %b nxt %h want 00000000 1 00000004", pc_current, active, pc_next);
    end
  endtask

  task automatic test_halt();
    do_reset();
    jump_reg        = 1'b1;
    jump_reg_target = 32'h00000000;
    step();
    clear_req();
    n_cmp++;
    if (pc_current !== 32'hBFC00004 || delay_slot !== 1'b1 || active !== 1'b1) begin
      n_err++; $display("FAIL halt_slot: pc %h ds %b act %b want BFC00004 1 1", pc_current, delay_slot, active);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'h00000000 || active !== 1'b0 || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL halt_enter: pc %h act %b ds %b want 00000000 0 0", pc_current, active, delay_slot);
    end
    jump          = 1'b1;
    jump_index    = 26'h0000040;
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (pc_next !== 32'h0 || pc_current !== 32'h0 || active !== 1'b0 || delay_slot !== 1'b0) begin
        n_err++; $display("FAIL halt_hold_%0d: nxt %h pc %h act %b ds %b want 0 0 0 0", i, pc_next, pc_current, active, delay_slot);
      end
    end
    clear_req();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (pc_current !== 32'hBFC00000 || active !== 1'b1 || pc_next !== 32'hBFC00004) begin
      n_err++; $display("FAIL halt_reset: pc %h act %b nxt %h want BFC00000 1 BFC00004", pc_current, active, pc_next);
    end
  endtask

  task automatic test_stall();
    do_reset();
    // Request held while stalled in SEQ must not be captured.
    clk_enable    = 1'b0;
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    step();
    n_cmp++;
    if (delay_slot !== 1'b0 || pc_current !== 32'hBFC00000 || pc_next !== 32'hBFC00004) begin
      n_err++; $display("FAIL stall_seq: ds %b pc %h nxt %h want 0 BFC00000 BFC00004", delay_slot, pc_current, pc_next);
    end
    clk_enable = 1'b1;
    step();
    clear_req();
    clk_enable = 1'b0;
    jump       = 1'b1;
    jump_index = 26'h0000040;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (pc_next !== 32'hBFC00010 || delay_slot !== 1'b1 || pc_current !== 32'hBFC00004) begin
        n_err++; $display("FAIL stall_delay_%0d: nxt %h ds %b pc %h want BFC00010 1 BFC00004", i, pc_next, delay_slot, pc_current);
      end
    end
    clear_req();
    clk_enable = 1'b1;
    step();
    n_cmp++;
    if (pc_current !== 32'hBFC00010 || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL stall_resume: pc %h ds %b want BFC00010 0", pc_current, delay_slot);
    end
  endtask

  task automatic test_reset_in_delay();
    do_reset();
    branch_taken  = 1'b1;
    branch_offset = 16'h0003;
    step();
    clear_req();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (pc_next !== 32'hBFC00000) begin
      n_err++; $display("FAIL rst_delay_nxt: nxt %h want BFC00000", pc_next);
    end
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (pc_current !== 32'hBFC00000 || delay_slot !== 1'b0 || active !== 1'b1) begin
      n_err++; $display("FAIL rst_delay_state: pc %h ds %b act %b want BFC00000 0 1", pc_current, delay_slot, active);
    end
    step();
    n_cmp++;
    if (pc_current !== 32'hBFC00004 || delay_slot !== 1'b0) begin
      n_err++; $display("FAIL rst_delay_discard: pc %h ds %b want BFC00004 0", pc_current, delay_slot);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    pc_current = 32'h0;
    reset      = 1'b1;
    clk_enable = 1'b1;
    clear_req();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_priority();
    test_wrap();
    test_halt();
    test_stall();
    test_reset_in_delay();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
